program_loader: RTL and testbench

//   Boot-time loader in front of the rv32 core's instruction memory. Receives a byte

---
 rtl/program_loader.sv | 182 ++++++++++++++++++
 tb/tb_program_loader.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Boot loader: assembles a little-endian word stream into instruction memory, then releases the core.
// Optional trailing checksum word enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_resetn,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    S_LEN  = 3'd0,
    S_DATA = 3'd1,
    S_DONE = 3'd2,
    S_ERR  = 3'd3
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [23:0]           shift_q, shift_d;
  logic [31:0]           len_q, len_d;
  logic [ADDR_WIDTH:0]   word_cnt_q, word_cnt_d;
  logic                  in_ready_q, in_ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  core_resetn_q, core_resetn_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [31:0]           sum_q, sum_d;
`endif

  logic                  xfer_s;
  logic                  last_byte_s;
  logic [31:0]           word_s;

  assign xfer_s      = in_valid & in_ready_q;
  assign last_byte_s = xfer_s & (byte_cnt_q == 2'd3);
  // The fourth byte arrives on in_data; earlier three sit in shift_q with b0 lowest.
  assign word_s      = {in_data, shift_q};

  // Next-state and registered-output logic
  always_comb begin
    state_d       = state_q;
    byte_cnt_d    = byte_cnt_q;
    shift_d       = shift_q;
    len_d         = len_q;
    word_cnt_d    = word_cnt_q;
    we_d          = 1'b0;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    sum_d         = sum_q;
`endif

    if (xfer_s) begin
      byte_cnt_d = byte_cnt_q + 2'd1;
      shift_d    = word_s[31:8];
    end else begin
      byte_cnt_d = byte_cnt_q;
    end

    case (state_q)
      S_LEN: begin
        if (last_byte_s) begin
          len_d      = word_s;
          word_cnt_d = '0;
          if ((word_s == 32'd0) || (word_s > 32'(MAX_WORDS))) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_LEN;
        end
      end
      S_DATA: begin
        if (last_byte_s) begin
          we_d       = 1'b1;
          addr_d     = word_cnt_q[ADDR_WIDTH-1:0];
          wdata_d    = word_s;
          word_cnt_d = word_cnt_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          sum_d      = sum_q + word_s;
`endif
          if ((32'(word_cnt_q) + 32'd1) == len_q) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            state_d = S_CSUM;
`else
            state_d = S_DONE;
`endif
          end else begin
            state_d = S_DATA;
          end
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (last_byte_s) begin
          if (word_s == sum_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERR;
          end
        end else begin
          state_d = S_CSUM;
        end
      end
`endif
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase

    in_ready_d    = (state_d != S_DONE) && (state_d != S_ERR);
    // Release lags the final write by one cycle so the last word is in memory first.
    done_d        = (state_q == S_DONE);
    core_resetn_d = (state_q == S_DONE);
    error_d       = (state_d == S_ERR);
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_LEN;
      byte_cnt_q    <= 2'd0;
      shift_q       <= 24'd0;
      len_q         <= 32'd0;
      word_cnt_q    <= '0;
      in_ready_q    <= 1'b0;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      core_resetn_q <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q         <= 32'd0;
`endif
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      shift_q       <= shift_d;
      len_q         <= len_d;
      word_cnt_q    <= word_cnt_d;
      in_ready_q    <= in_ready_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      core_resetn_q <= core_resetn_d;
      done_q        <= done_d;
      error_q       <= error_d;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign imem_we     = we_q;
  assign imem_addr   = addr_q;
  assign imem_wdata  = wdata_q;
  assign core_resetn = core_resetn_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized bench for program_loader: stream images with random gaps, compare against an image-level model.
module tb_program_loader;
  localparam int AW = 6;
  localparam int MW = 40;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [7:0]    in_data = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_resetn;
  logic          done;
  logic          error;

  program_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MW)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_resetn(core_resetn), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int xfer_cnt = 0;
  int last_xfer = 0;
  int we_cnt = 0;
  int last_we_cyc = -1;
  int done_cyc = -1;
  int err_cyc = -1;
  logic [AW-1:0] cap_addr [0:63];
  logic [31:0]   cap_data [0:63];
  int            cap_xfers[0:63];
  logic [31:0]   img      [0:63];

  // Count accepted bytes and remember the cycle of the latest one.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!resetn) begin
      xfer_cnt <= 0;
    end else if (in_valid && in_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= cyc;
    end
  end

  // Capture write strobes and the first cycle done/error were seen.
  always @(negedge clk) begin
    if (!resetn) begin
      we_cnt   <= 0;
      done_cyc <= -1;
      err_cyc  <= -1;
    end else begin
      if (imem_we && we_cnt < 64) begin
        cap_addr[we_cnt]  <= imem_addr;
        cap_data[we_cnt]  <= imem_wdata;
        cap_xfers[we_cnt] <= xfer_cnt;
        we_cnt            <= we_cnt + 1;
        last_we_cyc       <= cyc;
      end
      if (done && done_cyc < 0) done_cyc <= cyc;
      if (error && err_cyc < 0) err_cyc <= cyc;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a negedge; returns on the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input int maxgap);
    int gap;
    bit ok;
    gap = int'($urandom_range(maxgap, 0));
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    in_data  = b;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(negedge clk);
    end
    if (!ok) check_val("ready_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input int maxgap);
    for (int i = 0; i < 4; i++) send_byte(8'(w >> (8 * i)), maxgap);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    resetn   = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  // Load img[0..len-1] and check it against the image-level expectation.
  task automatic run_image(input logic [31:0] len, input int maxgap,
                           input logic [31:0] csum_delta, input string tag);
    logic [31:0] sum;
    bit          bad_len;
    bit          ok;
    int          nw;
    int          xs;
    int          ws;
    do_reset();
    bad_len = (len == 32'd0) || (len > 32'(MW));
    nw      = bad_len ? 0 : int'(len);
    sum     = 32'd0;
    send_word(len, maxgap);
    for (int k = 0; k < nw; k++) begin
      send_word(img[k], maxgap);
      sum = sum + img[k];
    end
    ok = !bad_len;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    if (!bad_len) begin
      send_word(sum + csum_delta, maxgap);
      ok = (csum_delta == 32'd0);
    end
`endif
    in_valid = 1'b0;
    repeat (4) @(negedge clk);

    check_val({tag, "/we_cnt"}, 64'(we_cnt), 64'(nw));
    for (int k = 0; k < nw && k < we_cnt; k++) begin
      check_val({tag, $sformatf("/addr%0d", k)}, 64'(cap_addr[k]), 64'(k));
      check_val({tag, $sformatf("/data%0d", k)}, 64'(cap_data[k]), 64'(img[k]));
      check_val({tag, $sformatf("/xfers%0d", k)}, 64'(cap_xfers[k]), 64'(4 * (k + 2)));
    end
    check_val({tag, "/done"}, 64'(done), 64'(ok));
    check_val({tag, "/core_resetn"}, 64'(core_resetn), 64'(ok));
    check_val({tag, "/error"}, 64'(error), 64'(!ok));
    check_val({tag, "/in_ready"}, 64'(in_ready), 64'd0);
    if (ok) begin
      check_val({tag, "/done_lat"}, 64'(done_cyc), 64'(last_xfer + 2));
`ifndef PROGRAM_LOADER_CHECKSUM_EN
      check_val({tag, "/we_lat"}, 64'(last_we_cyc), 64'(last_xfer + 1));
`endif
    end else begin
      check_val({tag, "/err_lat"}, 64'(err_cyc), 64'(last_xfer + 1));
    end

    xs = xfer_cnt;
    ws = we_cnt;
    in_data  = 8'hA5;
    in_valid = 1'b1;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check_val({tag, "/post_xfer"}, 64'(xfer_cnt), 64'(xs));
    check_val({tag, "/post_we"}, 64'(we_cnt), 64'(ws));
  endtask

  initial begin
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst/in_ready", 64'(in_ready), 64'd0);
    check_val("rst/imem_we", 64'(imem_we), 64'd0);
    check_val("rst/imem_addr", 64'(imem_addr), 64'd0);
    check_val("rst/imem_wdata", 64'(imem_wdata), 64'd0);
    check_val("rst/core_resetn", 64'(core_resetn), 64'd0);
    check_val("rst/done", 64'(done), 64'd0);
    check_val("rst/error", 64'(error), 64'd0);
    resetn = 1'b1;
    @(negedge clk);
    check_val("rst/ready_after", 64'(in_ready), 64'd1);

    img[0] = 32'h00500093;
    img[1] = 32'h00100113;
    run_image(32'd2, 0, 32'd0, "b2b");
    run_image(32'd2, 5, 32'd0, "gaps");
    run_image(32'd0, 2, 32'd0, "len0");
    run_image(32'(MW + 1), 1, 32'd0, "len_over");

    for (int k = 0; k < MW; k++) img[k] = $urandom;
    run_image(32'(MW), 1, 32'd0, "len_max");

    do_reset();
    send_word(32'd2, 0);
    send_word(32'hDEADBEEF, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    img[0] = 32'h00A00513;
    run_image(32'd1, 2, 32'd0, "midrst");

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    img[0] = 32'h00500093;
    img[1] = 32'h00100113;
    run_image(32'd2, 0, 32'd1, "csum_bad");
`endif

    for (int r = 0; r < 4; r++) begin
      int len;
      len = int'($urandom_range(MW, 1));
      for (int k = 0; k < len; k++) img[k] = $urandom;
      run_image(32'(len), r, 32'd0, $sformatf("rand%0d", r));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
